// File: rtl/execute_mdu.sv
// Iterative multiply/divide unit for the execute stage: all eight RV M-extension ops
// on one shared shift-add / restoring-divide datapath, with single-cycle divide special cases.
module execute_mdu #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2,
  parameter int DIV_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  output logic [XLEN-1:0] result,
  output logic            ready,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int MW = XLEN + MUL_BITS;
  localparam logic [CW-1:0]   N_MUL   = CW'(XLEN / MUL_BITS);
  localparam logic [CW-1:0]   N_DIV   = CW'(XLEN / DIV_BITS);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_dword(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  state_t            state, state_nxt;
  logic [2:0]        op_sel;
  logic              neg_res;
  logic [XLEN-1:0]   opb;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]     rem;
  logic [CW-1:0]     cnt;

  logic            accept, is_div, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, special, neg_d;
  logic [XLEN-1:0] a_abs, b_abs, special_res;

  assign accept   = (state == IDLE) && enable && !kill;
  assign is_div   = op[2];
  assign a_signed = (op == 3'd1) || (op == 3'd2) || (op[2] && !op[0]);
  assign b_signed = (op == 3'd1) || (op[2] && !op[0]);
  assign a_neg    = a_signed && rdata1[XLEN-1];
  assign b_neg    = b_signed && rdata2[XLEN-1];
  assign a_abs    = neg_word(rdata1, a_neg);
  assign b_abs    = neg_word(rdata2, b_neg);
  assign div_zero = is_div && (rdata2 == '0);
  assign div_ovf  = op[2] && !op[0] && (rdata1 == MIN_NEG) && (&rdata2);
  assign special  = div_zero || div_ovf;
  // Remainder follows the dividend; quotient and products follow the operand sign product.
  assign neg_d    = (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);

  always_comb begin
    special_res = '1;
    if (div_zero) special_res = op[1] ? rdata1 : '1;
    else          special_res = op[1] ? '0 : MIN_NEG;
  end

  logic [MW-1:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  assign mul_sum = MW'(prod[2*XLEN-1:XLEN]) + MW'(opb) * MW'(prod[MUL_BITS-1:0]);
  assign mul_nxt = {mul_sum, prod[XLEN-1:MUL_BITS]};

  // Dividend shifts out of prod's low word while quotient bits shift in behind it.
  logic [XLEN:0]   div_r;
  logic [XLEN-1:0] div_q;
  always_comb begin
    div_r = rem;
    div_q = prod[XLEN-1:0];
    for (int i = 0; i < DIV_BITS; i++) begin
      div_r = {div_r[XLEN-1:0], div_q[XLEN-1]};
      div_q = {div_q[XLEN-2:0], 1'b0};
      if (div_r >= {1'b0, opb}) begin
        div_r    = div_r - {1'b0, opb};
        div_q[0] = 1'b1;
      end
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;
  always_comb begin
    prod_fix = neg_dword(prod, neg_res);
    quo_fix  = neg_word(prod[XLEN-1:0], neg_res);
    rem_fix  = neg_word(rem[XLEN-1:0], neg_res);
    case (op_sel)
      3'd0:             fix_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fix_res = quo_fix;
      default:          fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_sel  <= '0;
      neg_res <= 1'b0;
      opb     <= '0;
      prod    <= '0;
      rem     <= '0;
      cnt     <= '0;
      result  <= '0;
    end else if (accept) begin
      op_sel  <= op;
      neg_res <= neg_d;
      opb     <= b_abs;
      prod    <= {{XLEN{1'b0}}, a_abs};
      rem     <= '0;
      cnt     <= is_div ? N_DIV : N_MUL;
      if (special) result <= special_res;
    end else if (state == CALC) begin
      cnt <= cnt - CW'(1);
      if (op_sel[2]) begin
        prod[XLEN-1:0] <= div_q;
        rem            <= div_r;
      end else begin
        prod <= mul_nxt;
      end
    end else if ((state == FIX) && !kill) begin
      result <= fix_res;
    end
  end

  assign ready = (state == DONE) && !kill;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_execute_mdu.sv
// Scoreboard bench for execute_mdu: 32-bit default instance plus a 64-bit/MUL_BITS=4 instance.
module tb_execute_mdu;
  logic        clk = 1'b0, rst = 1'b0, enable = 1'b0, kill = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rdata1 = '0, rdata2 = '0, result;
  logic        ready, busy;

  logic        en64 = 1'b0, kill64 = 1'b0;
  logic [2:0]  op64 = 3'd0;
  logic [63:0] a64 = '0, b64 = '0, res64;
  logic        rdy64, busy64;

  int checks = 0, failures = 0, cyc = 0;
  logic [63:0] exp_q[$];

  execute_mdu dut (
    .clk(clk), .rst(rst), .enable(enable), .kill(kill), .op(op),
    .rdata1(rdata1), .rdata2(rdata2), .result(result), .ready(ready), .busy(busy)
  );

  execute_mdu #(.XLEN(64), .MUL_BITS(4), .DIV_BITS(1)) dut64 (
    .clk(clk), .rst(rst), .enable(en64), .kill(kill64), .op(op64),
    .rdata1(a64), .rdata2(b64), .result(res64), .ready(rdy64), .busy(busy64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sub;
    logic [63:0] ua, ub, p;
    sa  = $signed({{32{a[31]}}, a});
    sb  = $signed({{32{b[31]}}, b});
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sub = $signed(ub);
    case (o)
      3'd0: begin p = ua * ub;  return p[31:0];  end
      3'd1: begin p = sa * sb;  return p[63:32]; end
      3'd2: begin p = sa * sub; return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    enable = 1'b1; op = o; rdata1 = a; rdata2 = b;
  endtask

  task automatic finish_op(input string tag, input logic [31:0] exp, input int lat);
    int k; bit got; bit busy_ok; logic [63:0] e;
    k = 0; got = 0; busy_ok = 1;
    exp_q.push_back({32'b0, exp});
    @(posedge clk);
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      if (!busy) busy_ok = 0;
      if (ready) got = 1;
    end
    e = exp_q.pop_front();
    if (!got) check_val({tag, "_timeout"}, 64'd0, 64'd1);
    else begin
      check_val({tag, "_lat"}, 64'(k), 64'(lat));
      check_val({tag, "_res"}, {32'b0, result}, e);
      check_val({tag, "_busy"}, 64'(busy_ok), 64'd1);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string tag, input bit hold);
    @(negedge clk);
    start_op(o, a, b);
    finish_op(tag, exp, lat);
    if (!hold) enable = 1'b0;
  endtask

  initial begin
    int r1, k64, lat;
    bit got64;
    logic [2:0] ro;
    logic [31:0] ra, rb;
    logic [63:0] e64;

    repeat (2) @(negedge clk);
    check_val("rst_ready", 64'(ready), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_result", {32'b0, result}, 64'd0);
    check_val("rst64_ready", 64'(rdy64), 64'd0);
    check_val("rst64_busy", 64'(busy64), 64'd0);
    check_val("rst64_result", res64, 64'd0);
    rst = 1'b1;

    run_op(3'd0, 32'd7, 32'd6, 32'h0000_002A, 18, "mul_7x6", 0);
    @(negedge clk);
    check_val("mul_ready_once", 64'(ready), 64'd0);
    check_val("mul_idle", 64'(busy), 64'd0);
    check_val("mul_hold", {32'b0, result}, 64'h2A);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 18, "mulh_m1", 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 18, "mulhu_m1", 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18, "mulhsu_m1", 0);
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 18, "mul_m1", 0);

    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_m7_2", 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_m7_2", 0);
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34, "divu_big", 0);

    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0", 0);
    run_op(3'd7, 32'd5, 32'd0, 32'h0000_0005, 1, "remu_by0", 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf", 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf", 0);
    run_op(3'd4, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1, "div_by0", 0);
    run_op(3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, "rem_by0", 0);

    // Kill a DIV mid-CALC, then issue a MUL in the very next cycle.
    @(negedge clk);
    start_op(3'd4, 32'd100, 32'd7);
    @(posedge clk);
    repeat (5) @(negedge clk);
    kill = 1'b1; enable = 1'b0;
    @(negedge clk);
    kill = 1'b0;
    check_val("kill_busy", 64'(busy), 64'd0);
    check_val("kill_ready", 64'(ready), 64'd0);
    check_val("kill_result", {32'b0, result}, 64'hFFFF_FFFB);
    start_op(3'd0, 32'd3, 32'd3);
    finish_op("kill_mul3x3", 32'd9, 18);
    enable = 1'b0;

    // Kill during FIX must not update result.
    @(negedge clk);
    start_op(3'd0, 32'd5, 32'd5);
    @(posedge clk);
    repeat (17) @(negedge clk);
    check_val("fixkill_busy_pre", 64'(busy), 64'd1);
    kill = 1'b1; enable = 1'b0;
    @(negedge clk);
    kill = 1'b0;
    check_val("fixkill_ready", 64'(ready), 64'd0);
    check_val("fixkill_busy", 64'(busy), 64'd0);
    check_val("fixkill_result", {32'b0, result}, 64'd9);

    // kill together with enable in IDLE: no accept.
    @(negedge clk);
    start_op(3'd0, 32'd2, 32'd2);
    kill = 1'b1;
    @(negedge clk);
    check_val("idlekill_busy", 64'(busy), 64'd0);
    kill = 1'b0; enable = 1'b0;

    run_op(3'd0, 32'd2, 32'd3, 32'd6, 18, "b2b_first", 1);
    r1 = cyc;
    run_op(3'd0, 32'd4, 32'd3, 32'd12, 18, "b2b_second", 0);
    check_val("b2b_gap", 64'(cyc - r1), 64'd19);

    // Asynchronous reset mid-CALC, checked between clock edges.
    @(negedge clk);
    start_op(3'd0, 32'd9, 32'd9);
    @(posedge clk);
    repeat (5) @(negedge clk);
    check_val("arst_busy_pre", 64'(busy), 64'd1);
    #2 rst = 1'b0; enable = 1'b0;
    #1;
    check_val("arst_ready", 64'(ready), 64'd0);
    check_val("arst_busy", 64'(busy), 64'd0);
    check_val("arst_result", {32'b0, result}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      if (i == 5) begin ro = 3'd6; rb = 32'd13; end
      if (ro < 3'd4) lat = 18;
      else if (rb == 0 || (!ro[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) lat = 1;
      else lat = 34;
      run_op(ro, ra, rb, ref_mdu(ro, ra, rb), lat, "rand", 0);
    end

    // 64-bit build: MULHU 2^63 * 4.
    @(negedge clk);
    en64 = 1'b1; op64 = 3'd3; a64 = 64'h8000_0000_0000_0000; b64 = 64'd4;
    exp_q.push_back(64'h2);
    @(posedge clk);
    k64 = 0; got64 = 0;
    while (!got64 && k64 < 100) begin
      @(negedge clk);
      k64++;
      if (rdy64) got64 = 1;
    end
    en64 = 1'b0;
    e64 = exp_q.pop_front();
    if (!got64) check_val("mulhu64_timeout", 64'd0, 64'd1);
    else begin
      check_val("mulhu64_lat", 64'(k64), 64'd18);
      check_val("mulhu64_res", res64, e64);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/execute_mdu.md
Name: execute_mdu

Overview:
- Parametrised, iterative multiply/divide unit for the execute stage. Covers all eight RISC-V M-extension operations with one shared datapath.
- Generalises the fixed-width mul/div helpers. Width and bits retired per cycle are set by parameters. It adds single-cycle handling of divide special cases and a synchronous kill.
- Handshake matches the execute stage: `enable` is held high while the stage stalls, and `ready` pulses for one cycle when the result is valid.

Parameters:
- XLEN, 32, operand and result width (32 or 64).
- MUL_BITS, 2, multiplier bits retired per cycle; power of 2; must divide XLEN.
- DIV_BITS, 1, quotient bits retired per cycle; power of 2; must divide XLEN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- enable  in  1  request, level; must be held with stable operands until `ready`.
- kill  in  1  synchronous abort (pipeline clear).
- op  in  3  funct3 code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rdata1  in  XLEN  rs1 operand.
- rdata2  in  XLEN  rs2 operand.
- result  out  XLEN  registered result; valid while `ready`=1 and held until the next accept.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high in CALC, FIX and DONE.

Behaviour:
- Reset (`rst`=0, asynchronous): FSM goes to IDLE. `ready`=0, `busy`=0, `result`=0, all datapath registers cleared.
- States are IDLE, CALC, FIX, DONE.
- IDLE:
  - If `enable`=1 and `kill`=0, accept at the clock edge: latch `op` and operands, take absolute values for signed ops, record result sign.
  - Load counter N: N = XLEN/MUL_BITS for op<4, N = XLEN/DIV_BITS for op>=4.
  - Next state is CALC, except divide special cases, which go straight to DONE.
- Divide special cases:
  - Divisor = 0: DIV/DIVU give all ones; REM/REMU give `rdata1`.
  - Signed overflow (`rdata1` = 2^(XLEN-1), `rdata2` = all ones) for DIV/REM: quotient = 2^(XLEN-1), remainder = 0.
- CALC:
  - Multiply: radix-2^MUL_BITS shift-add on a 2*XLEN product register, MUL_BITS partial-product bits per cycle.
  - Divide: restoring division, DIV_BITS quotient bits per cycle.
  - Counter decrements each cycle. When it reaches 1, next state is FIX.
- FIX: apply sign correction (two's complement), then select the output word:
  - MUL: low XLEN bits of the product.
  - MULH, MULHSU, MULHU: high XLEN bits.
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
  - Sign rules: remainder takes the sign of the dividend. MULHSU treats only `rdata1` as signed.
  - Register `result` at the end of FIX; next state is DONE.
- DONE: `ready`=1 for exactly this cycle. `enable` is ignored. Next state is IDLE, so a new request can be accepted in the following cycle.
- Latency: with acceptance at edge ending cycle T, `ready` is high in cycle T+N+2 for normal ops and in cycle T+1 for special cases.
- `kill`=1 in any state:
  - Next state is IDLE; no `ready` is produced for the aborted op.
  - `ready` is forced to 0 combinationally while `kill`=1.
  - `kill` together with `enable` in IDLE: no accept.
  - `result` keeps its previous value.
- `enable` deasserted during CALC or FIX without `kill`: the op still completes and `ready` pulses. The stage must use `kill` to abort.
- Operand changes after accept have no effect.
- All arithmetic is modulo 2^XLEN on output. Internal product is 2*XLEN bits; remainder register is XLEN+1 bits.

Test Plan (XLEN=32, MUL_BITS=2, DIV_BITS=1 unless stated):
- MUL 7×6, accepted in cycle T -> `result`=0x0000002A, `ready` high only in cycle T+18, `busy` high T+1..T+18.
- 0xFFFFFFFF × 0xFFFFFFFF:
  - MULH -> 0x00000000.
  - MULHU -> 0xFFFFFFFE.
  - MULHSU -> 0xFFFFFFFF.
  - MUL -> 0x00000001.
- Signed divide, `ready` in cycle T+34 for each:
  - DIV -7/2 -> 0xFFFFFFFD.
  - REM -7/2 -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- Special cases, `ready` in cycle T+1 for each:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 0x00000005.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- Kill:
  - `kill` pulse in cycle T+5 of a DIV -> no `ready`; `busy`=0 from T+6; `result` unchanged.
  - MUL 3×3 issued at T+6 -> 9 with `ready` at T+24.
  - Back-to-back MULs with `enable` held -> second accepted in the cycle after DONE.
- Reset and parameter sweep:
  - `rst` low mid-CALC -> `ready`/`busy`/`result`=0 immediately, without waiting for a clock edge.
  - Rebuild XLEN=64, MUL_BITS=4: MULHU 2^63 × 4 -> 0x2, `ready` at T+18.
